// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_OUT = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_NOR = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SLL = 4'h8;
    localparam logic [3:0] OP_SRL = 4'h9;
    localparam logic [3:0] OP_SRA = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;
    localparam logic [3:0] OP_DIV = 4'hC;

    localparam int FLAG_EQ = 3;
    localparam int FLAG_NE = 2;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MULDIV = 2'd2,
        ST_RESP   = 2'd3
    } seq_state_e;

    // Opcodes the combinational ALU actually implements.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_OUT) || ((op >= OP_ADD) && (op <= OP_SRA));
    endfunction

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshakes plus ALU-facing signals of the sequencer, bundled as one interface.
interface alu_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [TAG_W-1:0]  cmd_tag;

    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_data0;
    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_out_data;
    logic              alu_ovf;
    logic [3:0]        alu_condition;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_ovf;
    logic              rsp_err;
    logic [3:0]        flags;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output alu_opcode, alu_data0, alu_data1,
        input  alu_out_data, alu_ovf, alu_condition,
        output rsp_valid, rsp_data, rsp_tag, rsp_ovf, rsp_err, flags,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  alu_opcode, alu_data0, alu_data1,
        output alu_out_data, alu_ovf, alu_condition,
        input  rsp_valid, rsp_data, rsp_tag, rsp_ovf, rsp_err, flags,
        output rsp_ready
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Instantiated by alu_sequencer only when ALU_SEQ_MULDIV_EN is defined.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              ovf_o,
    output logic              dz_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              busy_q, busy_d;
    logic              div_q, div_d;
    logic              dz_q, dz_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;

    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_trial;
    logic [DATA_W-1:0] acc_nx;
    logic [DATA_W-1:0] lo_nx;

    // acc:lo is the 64-bit product register for MUL and remainder:quotient for DIV.
    always_comb begin
        addend    = lo_q[0] ? opnd_q : {DATA_W{1'b0}};
        mul_sum   = {1'b0, acc_q} + {1'b0, addend};
        div_trial = {acc_q, lo_q[DATA_W-1]} - {1'b0, opnd_q};
        if (div_q) begin
            if (div_trial[DATA_W]) begin
                acc_nx = {acc_q[DATA_W-2:0], lo_q[DATA_W-1]};
                lo_nx  = {lo_q[DATA_W-2:0], 1'b0};
            end else begin
                acc_nx = div_trial[DATA_W-1:0];
                lo_nx  = {lo_q[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_nx = mul_sum[DATA_W:1];
            lo_nx  = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
    end

    // The last step is taken combinationally so the result is ready in the 32nd busy cycle.
    assign done_o   = busy_q && (dz_q || (cnt_q == CNT_W'(DATA_W - 1)));
    assign result_o = dz_q ? {DATA_W{1'b1}} : lo_nx;
    assign ovf_o    = !div_q && (acc_nx != {DATA_W{1'b0}});
    assign dz_o     = dz_q;

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        dz_d   = dz_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        if (start_i) begin
            busy_d = 1'b1;
            div_d  = (op_i == OP_DIV);
            dz_d   = (op_i == OP_DIV) && (b_i == {DATA_W{1'b0}});
            cnt_d  = '0;
            acc_d  = '0;
            lo_d   = (op_i == OP_DIV) ? a_i : b_i;
            opnd_d = (op_i == OP_DIV) ? b_i : a_i;
        end else if (busy_q) begin
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                acc_d = acc_nx;
                lo_d  = lo_nx;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            dz_q   <= dz_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Front end for the combinational ALU: one request in flight, tagged response, SUB-updated flags.
// Define ALU_SEQ_MULDIV_EN to add iterative MUL/DIV; otherwise those opcodes return an error.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.slave bus
);

    seq_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic              rsp_err_q, rsp_err_d;
    logic [3:0]        flags_q, flags_d;

    logic              accept;
    logic              exec_legal;

    assign accept     = bus.cmd_valid && (state_q == ST_IDLE);
    assign exec_legal = is_alu_op(op_q);

`ifdef ALU_SEQ_MULDIV_EN
    logic              md_start;
    logic              md_done;
    logic [DATA_W-1:0] md_result;
    logic              md_ovf;
    logic              md_dz;

    assign md_start = accept && is_muldiv_op(bus.cmd_op);

    alu_muldiv_iter #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .op_i     (bus.cmd_op),
        .a_i      (bus.cmd_a),
        .b_i      (bus.cmd_b),
        .done_o   (md_done),
        .result_o (md_result),
        .ovf_o    (md_ovf),
        .dz_o     (md_dz)
    );
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_err_d  = rsp_err_q;
        flags_d    = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = bus.cmd_op;
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    tag_d   = bus.cmd_tag;
                    state_d = ST_EXEC;
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_muldiv_op(bus.cmd_op)) state_d = ST_MULDIV;
`endif
                end
            end
            ST_EXEC: begin
                // Opcodes the ALU lacks still take the EXEC slot so latency stays uniform.
                rsp_data_d = exec_legal ? bus.alu_out_data : {DATA_W{1'b0}};
                rsp_ovf_d  = exec_legal && ((op_q == OP_ADD) || (op_q == OP_SUB)) && bus.alu_ovf;
                rsp_err_d  = !exec_legal;
                if (op_q == OP_SUB) flags_d = bus.alu_condition;
                state_d    = ST_RESP;
            end
            ST_MULDIV: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (md_done) begin
                    rsp_data_d = md_result;
                    rsp_ovf_d  = md_ovf;
                    rsp_err_d  = md_dz;
                    state_d    = ST_RESP;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_err_q  <= rsp_err_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.alu_opcode = op_q;
    assign bus.alu_data0  = a_q;
    assign bus.alu_data1  = b_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.flags      = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and an expected-response queue.
// Covers both builds; MUL/DIV expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        ovf;
        logic        err;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_sequencer_if #(.DATA_W(32), .TAG_W(4)) bus ();

    alu_sequencer #(.DATA_W(32), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; ovf is meaningless outside ADD/SUB so it is driven high there.
    logic [31:0] alu_r;
    always_comb begin
        alu_r       = 32'h0;
        bus.alu_ovf = 1'b1;
        case (bus.alu_opcode)
            4'h0: alu_r = bus.alu_data0;
            4'h2: begin
                alu_r       = bus.alu_data0 + bus.alu_data1;
                bus.alu_ovf = (bus.alu_data0[31] == bus.alu_data1[31]) && (alu_r[31] != bus.alu_data0[31]);
            end
            4'h3: begin
                alu_r       = bus.alu_data0 - bus.alu_data1;
                bus.alu_ovf = (bus.alu_data0[31] != bus.alu_data1[31]) && (alu_r[31] != bus.alu_data0[31]);
            end
            4'h4: alu_r = bus.alu_data0 & bus.alu_data1;
            4'h5: alu_r = bus.alu_data0 | bus.alu_data1;
            4'h6: alu_r = ~(bus.alu_data0 | bus.alu_data1);
            4'h7: alu_r = bus.alu_data0 ^ bus.alu_data1;
            4'h8: alu_r = bus.alu_data0 << bus.alu_data1[4:0];
            4'h9: alu_r = bus.alu_data0 >> bus.alu_data1[4:0];
            4'hA: alu_r = $unsigned($signed(bus.alu_data0) >>> bus.alu_data1[4:0]);
            default: alu_r = 32'h1234_5678;
        endcase
        bus.alu_out_data  = alu_r;
        bus.alu_condition = {bus.alu_data0 == bus.alu_data1,
                             bus.alu_data0 != bus.alu_data1,
                             $signed(bus.alu_data0) > $signed(bus.alu_data1),
                             $signed(bus.alu_data0) < $signed(bus.alu_data1)};
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input bit push, input logic [31:0] e_data,
                         input logic e_ovf, input logic e_err, input logic [3:0] e_flags, input int e_lat);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_accept", {31'b0, bus.cmd_ready}, 32'd1);
        if (push) begin
            e.data = e_data; e.tag = tag; e.ovf = e_ovf; e.err = e_err; e.flags = e_flags; e.lat = e_lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic collect(input bit do_ack);
        exp_t e;
        int   lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 100);
        chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_tag", {28'b0, bus.rsp_tag}, {28'b0, e.tag});
            chk("rsp_ovf", {31'b0, bus.rsp_ovf}, {31'b0, e.ovf});
            chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
            chk("flags", {28'b0, bus.flags}, {28'b0, e.flags});
            chk("latency", lat, e.lat);
        end
        if (do_ack) begin
            @(posedge clk);
            @(negedge clk);
            chk("rsp_valid_after_ack", {31'b0, bus.rsp_valid}, 32'd0);
            chk("cmd_ready_after_ack", {31'b0, bus.cmd_ready}, 32'd1);
        end
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({pfx, "_cmd_ready"}, {31'b0, bus.cmd_ready}, 32'd1);
        chk({pfx, "_flags"}, {28'b0, bus.flags}, 32'd0);
        chk({pfx, "_rsp_data"}, bus.rsp_data, 32'd0);
        chk({pfx, "_rsp_tag"}, {28'b0, bus.rsp_tag}, 32'd0);
        chk({pfx, "_rsp_ovf_err"}, {30'b0, bus.rsp_ovf, bus.rsp_err}, 32'd0);
        chk({pfx, "_alu_opcode"}, {28'b0, bus.alu_opcode}, 32'd0);
        chk({pfx, "_alu_data"}, bus.alu_data0 | bus.alu_data1, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_a     = 32'h0;
        bus.cmd_b     = 32'h0;
        bus.cmd_tag   = 4'h0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        issue(4'h2, 32'h7FFF_FFFF, 32'h1, 4'h3, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 4'b0000, 2);
        collect(1'b1);
        issue(4'h3, 32'd5, 32'd5, 4'h1, 1'b1, 32'h0, 1'b0, 1'b0, 4'b1000, 2);
        collect(1'b1);
        issue(4'h3, 32'd3, 32'd5, 4'h2, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4'b0101, 2);
        collect(1'b1);
        issue(4'h4, 32'h0000_FF00, 32'h0000_00F0, 4'h4, 1'b1, 32'h0, 1'b0, 1'b0, 4'b0101, 2);
        collect(1'b1);
        issue(4'hA, 32'h8000_0000, 32'd4, 4'h6, 1'b1, 32'hF800_0000, 1'b0, 1'b0, 4'b0101, 2);
        collect(1'b1);
        issue(4'h7, 32'hA5A5_A5A5, 32'hFFFF_0000, 4'h7, 1'b1, 32'h5A5A_A5A5, 1'b0, 1'b0, 4'b0101, 2);
        collect(1'b1);

        // Back-pressure: response held for 5 cycles while the next command waits.
        bus.rsp_ready = 1'b0;
        issue(4'h2, 32'd10, 32'd20, 4'h5, 1'b1, 32'd30, 1'b0, 1'b0, 4'b0101, 2);
        collect(1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'h3;
        bus.cmd_a     = 32'h8000_0000;
        bus.cmd_b     = 32'h1;
        bus.cmd_tag   = 4'h9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("stall_rsp_data", bus.rsp_data, 32'd30);
            chk("stall_rsp_tag", {28'b0, bus.rsp_tag}, 32'd5);
            chk("stall_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("release_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        sb.push_back('{data: 32'h7FFF_FFFF, tag: 4'h9, ovf: 1'b1, err: 1'b0, flags: 4'b0101, lat: 2});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        collect(1'b1);

        issue(4'hE, 32'd7, 32'd7, 4'hA, 1'b1, 32'h0, 1'b0, 1'b1, 4'b0101, 2);
        collect(1'b1);

`ifdef ALU_SEQ_MULDIV_EN
        issue(4'hB, 32'h0001_0000, 32'h0001_0000, 4'hB, 1'b1, 32'h0, 1'b1, 1'b0, 4'b0101, 33);
        collect(1'b1);
        issue(4'hB, 32'd2, 32'd3, 4'hC, 1'b1, 32'd6, 1'b0, 1'b0, 4'b0101, 33);
        collect(1'b1);
        issue(4'hC, 32'd100, 32'd7, 4'hD, 1'b1, 32'd14, 1'b0, 1'b0, 4'b0101, 33);
        collect(1'b1);
        issue(4'hC, 32'd9, 32'd0, 4'hE, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'b0101, 2);
        collect(1'b1);
        // Reset lands in the 10th MULDIV cycle of a long multiply.
        issue(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 0);
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", {31'b0, bus.rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midop_reset");
        rst = 1'b0;
`else
        issue(4'hB, 32'd2, 32'd3, 4'hB, 1'b1, 32'h0, 1'b0, 1'b1, 4'b0101, 2);
        collect(1'b1);
        issue(4'hC, 32'd100, 32'd7, 4'hC, 1'b1, 32'h0, 1'b0, 1'b1, 4'b0101, 2);
        collect(1'b1);
        // Reset lands while a response is pending.
        bus.rsp_ready = 1'b0;
        issue(4'h2, 32'd1, 32'd2, 4'h8, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 0);
        repeat (3) @(negedge clk);
        chk("pre_reset_pending", {31'b0, bus.rsp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("pending_reset");
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
`endif

        issue(4'h2, 32'd1, 32'd1, 4'hF, 1'b1, 32'd2, 1'b0, 1'b0, 4'b0000, 2);
        collect(1'b1);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side front end for the combinational ALU: accepts operation requests over a valid/ready handshake, drives the ALU opcode/operand inputs from registers, captures result, overflow and condition code, and returns a tagged response over a second valid/ready handshake. Maintains the architectural condition-flag register (EQ,NE,GT,LT) updated only by SUB. Optionally implements MUL/DIV iteratively, since the ALU leaves those opcodes empty.

## Interface
- DATA_W, 32, operand/result width (ALU is fixed at 32)
- TAG_W, 4, request tag width, returned unchanged with response
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  sequencer can accept request
- cmd_op  in  4  opcode: 0 OUT, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR, 8 SLL, 9 SRL, A SRA, B MUL, C DIV
- cmd_a / cmd_b  in  DATA_W  operands A/B
- cmd_tag  in  TAG_W  request tag
- alu_opcode  out  4  to ALU opcode, driven from registered op
- alu_data0 / alu_data1  out  DATA_W  to ALU data0/data1, registered
- alu_out_data  in  DATA_W  ALU result
- alu_ovf  in  1  ALU overflow
- alu_condition  in  4  ALU status {EQ,NE,GT,LT}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  result
- rsp_tag  out  TAG_W  tag of the completed request
- rsp_ovf  out  1  overflow
- rsp_err  out  1  illegal opcode / unsupported op / divide by zero
- flags  out  4  registered {EQ,NE,GT,LT}

## Operation
- FSM states: IDLE, EXEC, MULDIV, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready latch op, a, b, tag. Next: MULDIV if op∈{B,C} and MULDIV enabled, else EXEC.
- EXEC (1 cycle): ALU sees registered op/operands. Capture alu_out_data → rsp_data. rsp_ovf = alu_ovf for ADD/SUB, else 0. If op==SUB, flags ← alu_condition; otherwise flags hold. Next: RESP.
- Illegal opcodes (1, D, E, F; B/C when MULDIV disabled): pass through EXEC, rsp_data=0, rsp_ovf=0, rsp_err=1, flags unchanged.
- MULDIV: see Configuration. Next: RESP when done.
- RESP: rsp_valid=1; rsp_* stable while rsp_ready=0. On rsp_ready → IDLE.
- cmd_ready=0 in every state except IDLE; at most one operation in flight.
- Reset values: state IDLE, cmd_ready 1 (combinational from state), rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_ovf 0, rsp_err 0, flags 0000, alu_opcode 0, alu_data0/1 0, iteration counter 0.
- rst in any state, including mid-MULDIV or in RESP with a pending response: in-flight operation discarded, all registers to reset values on that edge.

## Timing
- Accept at edge N → EXEC in cycle N+1 → rsp_valid high from cycle N+2 (2-cycle latency).
- MUL/DIV: 32 MULDIV cycles → rsp_valid from 33 cycles after accept; DIV by zero: 1 MULDIV cycle → 2-cycle latency.
- Response accepted at edge M → cmd_ready high in cycle M+1; best-case throughput 1 op per 3 cycles.
- flags update at the EXEC→RESP edge, visible together with rsp_valid.

## Configuration
- ALU_SEQ_MULDIV_EN defined: MUL = unsigned shift-add, 32 iterations, rsp_data = low 32 bits of product, rsp_ovf=1 iff high 32 bits nonzero. DIV = unsigned restoring division, 32 iterations, rsp_data = quotient; divisor 0 → rsp_data=FFFF_FFFF, rsp_err=1, rsp_ovf=0. flags not affected.
- Not defined: no MULDIV state or datapath logic; B/C handled as illegal opcodes.

## Structure
- Shared package alu_pkg: opcode constants (4-bit), FSM state enum, flag bit indices (EQ=3, NE=2, GT=1, LT=0).
- Sub-module alu_muldiv_iter (start, op, a, b → done, result, ovf, dz), instantiated only under ALU_SEQ_MULDIV_EN.

## Test plan
- ADD 7FFF_FFFF+1, tag 3 → rsp_data 8000_0000, rsp_ovf 1, rsp_tag 3, rsp_valid 2 cycles after accept, flags 0000.
- SUB 5−5 → rsp_data 0, flags 1000; then SUB 3−5 → rsp_data FFFF_FFFE, flags 0101; then AND → flags stay 0101.
- Hold rsp_ready low 5 cycles after rsp_valid → rsp_* stable, cmd_ready 0; new cmd accepted the cycle after rsp_ready.
- With macro: MUL 0001_0000×0001_0000 → data 0, ovf 1, latency 33; DIV 100/7 → 14; DIV 9/0 → FFFF_FFFF, err 1, latency 2.
- cmd_op E → rsp_data 0, rsp_err 1, flags unchanged; without macro, MUL 2×3 → rsp_err 1, data 0.
- rst asserted in 10th MULDIV cycle → next cycle rsp_valid 0, cmd_ready 1, flags 0000; following ADD 1+1 → 2 normally.
